// File: rtl/xor_session_ctrl.sv
// xor_session_ctrl: sequencer for one XOR-cipher session.
// The FSM clears the datapath, loads the key and then the message through the
// deserializers, and then waits for the encryptor and the serializer to finish.
// The optional watchdog / ERROR state is enabled by defining XOR_CTRL_WDT_EN.
// Without that macro, the active states wait indefinitely and oError is tied low.
module xor_session_ctrl #(
    parameter int KEY_SIZE = 32,
    parameter int MSG_SIZE = 512,
    parameter int TIMEOUT  = 1024
) (
    input  logic                      iClk,
    input  logic                      iRst,
    input  logic                      iStart,
    input  logic                      iAbort,
    input  logic                      iSerial_valid,
    input  logic [$clog2(KEY_SIZE):0] iBit_counter_key,
    input  logic [$clog2(MSG_SIZE):0] iBit_counter_msg,
    input  logic                      iCan_encrypt,
    input  logic                      iEncrypt_done,
    input  logic                      iSerial_end,
    output logic                      oDp_rst_n,
    output logic                      oLoad_key,
    output logic                      oLoad_msg,
    output logic                      oEn,
    output logic                      oBusy,
    output logic                      oDone,
    output logic                      oError,
    output logic [2:0]                oState
);

    localparam int KW = $clog2(KEY_SIZE) + 1;
    localparam int MW = $clog2(MSG_SIZE) + 1;
    localparam logic [KW-1:0] KEY_TGT = KW'(KEY_SIZE);
    localparam logic [MW-1:0] MSG_TGT = MW'(MSG_SIZE);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CLEAR     = 3'd1,
        S_LOAD_KEY  = 3'd2,
        S_LOAD_MSG  = 3'd3,
        S_ENCRYPT   = 3'd4,
        S_SHIFT_OUT = 3'd5,
        S_DONE      = 3'd6,
        S_ERROR     = 3'd7
    } state_t;

    state_t state_q, state_d;
    logic   clr_cnt_q, clr_cnt_d;
    logic   dp_rst_n_q, dp_rst_n_d;
    logic   load_key_q, load_key_d;
    logic   load_msg_q, load_msg_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;
    logic   abort_dp;
    logic   en_c;
    logic   wdt_expired;

    // A stalled key assembler is detected by the watchdog, so this ready flag is not decoded
    logic   unused_can_encrypt;
    assign unused_can_encrypt = iCan_encrypt;

    // The shift enable follows the host valid bit while either deserializer is loading
    assign en_c = iSerial_valid && ((state_q == S_LOAD_KEY) || (state_q == S_LOAD_MSG));

`ifdef XOR_CTRL_WDT_EN
    localparam int WW = $clog2(TIMEOUT) + 1;
    localparam logic [WW-1:0] WDT_LIMIT = WW'(TIMEOUT);

    logic [WW-1:0] wdt_q, wdt_d;
    logic          error_q, error_d;

    assign wdt_expired = (wdt_q >= WDT_LIMIT);

    // The watchdog restarts on progress and counts idle cycles in the waiting states, saturating at the limit
    always_comb begin
        wdt_d = wdt_q;
        if ((state_d != state_q) || en_c) begin
            wdt_d = '0;
        end else if ((state_q inside {S_LOAD_KEY, S_LOAD_MSG, S_ENCRYPT, S_SHIFT_OUT})
                     && (wdt_q < WDT_LIMIT)) begin
            wdt_d = wdt_q + WW'(1);
        end
    end

    assign error_d = (state_d == S_ERROR);
    assign oError  = error_q;
`else
    localparam int unused_timeout = TIMEOUT;
    assign wdt_expired = 1'b0;
    assign oError      = 1'b0;
`endif

    // Next state: abort overrides everything; the watchdog yields to real progress in the same cycle
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        abort_dp  = 1'b0;
        if (iAbort) begin
            if (state_q != S_IDLE) begin
                state_d = S_IDLE;
            end
            abort_dp = (state_q != S_IDLE) && (state_q != S_ERROR);
        end else begin
            case (state_q)
                S_IDLE, S_ERROR: begin
                    if (iStart) begin
                        state_d   = S_CLEAR;
                        clr_cnt_d = 1'b0;
                    end
                end
                S_CLEAR: begin
                    clr_cnt_d = 1'b1;
                    if (clr_cnt_q) begin
                        state_d = S_LOAD_KEY;
                    end
                end
                S_LOAD_KEY: begin
                    if (iBit_counter_key >= KEY_TGT) begin
                        state_d = S_LOAD_MSG;
                    end else if (wdt_expired) begin
                        state_d = S_ERROR;
                    end
                end
                S_LOAD_MSG: begin
                    if (iBit_counter_msg >= MSG_TGT) begin
                        state_d = S_ENCRYPT;
                    end else if (wdt_expired) begin
                        state_d = S_ERROR;
                    end
                end
                S_ENCRYPT: begin
                    if (iEncrypt_done) begin
                        state_d = S_SHIFT_OUT;
                    end else if (wdt_expired) begin
                        state_d = S_ERROR;
                    end
                end
                S_SHIFT_OUT: begin
                    if (iSerial_end) begin
                        state_d = S_DONE;
                    end else if (wdt_expired) begin
                        state_d = S_ERROR;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Registered outputs are decoded from the next state so they line up with oState
    always_comb begin
        dp_rst_n_d = !((state_d == S_CLEAR) || abort_dp);
        load_key_d = (state_d == S_LOAD_KEY);
        load_msg_d = (state_d == S_LOAD_MSG);
        busy_d     = (state_d inside {S_CLEAR, S_LOAD_KEY, S_LOAD_MSG, S_ENCRYPT, S_SHIFT_OUT});
        done_d     = (state_d == S_DONE);
    end

    // State, clear counter, watchdog and output registers
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state_q    <= S_IDLE;
            clr_cnt_q  <= 1'b0;
            dp_rst_n_q <= 1'b1;
            load_key_q <= 1'b0;
            load_msg_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef XOR_CTRL_WDT_EN
            wdt_q      <= '0;
            error_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            dp_rst_n_q <= dp_rst_n_d;
            load_key_q <= load_key_d;
            load_msg_q <= load_msg_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef XOR_CTRL_WDT_EN
            wdt_q      <= wdt_d;
            error_q    <= error_d;
`endif
        end
    end

    assign oDp_rst_n = dp_rst_n_q;
    assign oLoad_key = load_key_q;
    assign oLoad_msg = load_msg_q;
    assign oEn       = en_c;
    assign oBusy     = busy_q;
    assign oDone     = done_q;
    assign oState    = state_q;

endmodule

// File: tb/tb_xor_session_ctrl.sv
// Directed bench for xor_session_ctrl (KEY_SIZE=32, MSG_SIZE=512, TIMEOUT=16).
`timescale 1ns/1ps
module tb_xor_session_ctrl;

    localparam int KEY_SIZE = 32;
    localparam int MSG_SIZE = 512;
    localparam int TIMEOUT  = 16;
    localparam int KW = $clog2(KEY_SIZE) + 1;
    localparam int MW = $clog2(MSG_SIZE) + 1;

    logic          iClk = 1'b0;
    logic          iRst;
    logic          iStart, iAbort, iSerial_valid;
    logic [KW-1:0] iBit_counter_key;
    logic [MW-1:0] iBit_counter_msg;
    logic          iCan_encrypt, iEncrypt_done, iSerial_end;
    logic          oDp_rst_n, oLoad_key, oLoad_msg, oEn, oBusy, oDone, oError;
    logic [2:0]    oState;

    int checks   = 0;
    int failures = 0;

    xor_session_ctrl #(.KEY_SIZE(KEY_SIZE), .MSG_SIZE(MSG_SIZE), .TIMEOUT(TIMEOUT)) dut (
        .iClk(iClk), .iRst(iRst), .iStart(iStart), .iAbort(iAbort),
        .iSerial_valid(iSerial_valid), .iBit_counter_key(iBit_counter_key),
        .iBit_counter_msg(iBit_counter_msg), .iCan_encrypt(iCan_encrypt),
        .iEncrypt_done(iEncrypt_done), .iSerial_end(iSerial_end),
        .oDp_rst_n(oDp_rst_n), .oLoad_key(oLoad_key), .oLoad_msg(oLoad_msg),
        .oEn(oEn), .oBusy(oBusy), .oDone(oDone), .oError(oError), .oState(oState)
    );

    always #5 iClk = ~iClk;

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic clear_inputs();
        iStart = 0; iAbort = 0; iSerial_valid = 0;
        iBit_counter_key = '0; iBit_counter_msg = '0;
        iCan_encrypt = 0; iEncrypt_done = 0; iSerial_end = 0;
    endtask

    // Start a session and run it through the two CLEAR cycles into LOAD_KEY
    task automatic enter_load_key();
        iStart = 1; step(); iStart = 0; step(); step();
    endtask

    task automatic test_reset();
        logic [8:0] got;
        clear_inputs();
        iRst = 0;
        step(); step();
        got = {oState, oDp_rst_n, oLoad_key, oLoad_msg, oBusy, oDone, oError};
        checks++;
        if (got !== 9'b000_1_00000) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected %b", got, 9'b000_1_00000);
        end
        iRst = 1;
        step();
        checks++;
        if (oState !== 3'd0) begin
            failures++;
            $display("FAIL reset_idle_state: got %0d expected 0", oState);
        end
    endtask

    task automatic test_nominal();
        bit busy_ok = 1;
        bit stay_ok = 1;
        clear_inputs();
        iCan_encrypt = 1;
        iStart = 1; step(); iStart = 0;
        checks++;
        if ({oState, oDp_rst_n, oBusy} !== {3'd1, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL nom_clear1: got state=%0d dp=%b busy=%b expected 1 0 1", oState, oDp_rst_n, oBusy);
        end
        step();
        checks++;
        if ({oState, oDp_rst_n} !== {3'd1, 1'b0}) begin
            failures++;
            $display("FAIL nom_clear2: got state=%0d dp=%b expected 1 0", oState, oDp_rst_n);
        end
        step();
        checks++;
        if ({oState, oDp_rst_n, oLoad_key} !== {3'd2, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL nom_load_key: got state=%0d dp=%b lk=%b expected 2 1 1", oState, oDp_rst_n, oLoad_key);
        end
        for (int i = 0; i < KEY_SIZE; i++) begin
            iSerial_valid = 1; iBit_counter_key = KW'(i);
            #1;
            if (oEn !== 1'b1) stay_ok = 0;
            step();
            if (oState !== 3'd2) stay_ok = 0;
            if (oBusy !== 1'b1) busy_ok = 0;
        end
        iBit_counter_key = KW'(KEY_SIZE);
        step();
        checks++;
        if ({oState, oLoad_key, oLoad_msg} !== {3'd3, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL nom_load_msg: got state=%0d lk=%b lm=%b expected 3 0 1", oState, oLoad_key, oLoad_msg);
        end
        for (int i = 0; i < MSG_SIZE; i++) begin
            iBit_counter_msg = MW'(i);
            #1;
            if (oEn !== 1'b1) stay_ok = 0;
            step();
            if (oState !== 3'd3) stay_ok = 0;
            if (oBusy !== 1'b1) busy_ok = 0;
        end
        checks++;
        if (stay_ok !== 1'b1) begin
            failures++;
            $display("FAIL nom_load_phases: got ok=%b expected 1", stay_ok);
        end
        iBit_counter_msg = MW'(MSG_SIZE);
        step();
        #1;
        checks++;
        if ({oState, oEn} !== {3'd4, 1'b0}) begin
            failures++;
            $display("FAIL nom_encrypt: got state=%0d en=%b expected 4 0", oState, oEn);
        end
        iSerial_valid = 0;
        iStart = 1;
        step(); step();
        iStart = 0;
        checks++;
        if ({oState, oBusy} !== {3'd4, 1'b1}) begin
            failures++;
            $display("FAIL start_in_encrypt_ignored: got state=%0d busy=%b expected 4 1", oState, oBusy);
        end
        iEncrypt_done = 1; step(); iEncrypt_done = 0;
        if (oBusy !== 1'b1) busy_ok = 0;
        step();
        checks++;
        if (oState !== 3'd5) begin
            failures++;
            $display("FAIL nom_shift_out: got %0d expected 5", oState);
        end
        iSerial_end = 1; step(); iSerial_end = 0;
        checks++;
        if ({oState, oDone, oBusy} !== {3'd6, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL nom_done: got state=%0d done=%b busy=%b expected 6 1 0", oState, oDone, oBusy);
        end
        step();
        checks++;
        if ({oState, oDone} !== {3'd0, 1'b0}) begin
            failures++;
            $display("FAIL nom_back_idle: got state=%0d done=%b expected 0 0", oState, oDone);
        end
        checks++;
        if (busy_ok !== 1'b1) begin
            failures++;
            $display("FAIL nom_busy_held: got ok=%b expected 1", busy_ok);
        end
        clear_inputs();
    endtask

    task automatic test_gapped();
        bit v;
        clear_inputs();
        enter_load_key();
        for (int i = 0; i < 6; i++) begin
            v = (i % 2 == 0);
            iSerial_valid = v;
            iBit_counter_key = KW'(26 + i);
            #1;
            checks++;
            if (oEn !== v) begin
                failures++;
                $display("FAIL gap_en_mirror: got %b expected %b", oEn, v);
            end
            step();
        end
        iBit_counter_key = KW'(KEY_SIZE - 1);
        step();
        checks++;
        if (oState !== 3'd2) begin
            failures++;
            $display("FAIL gap_hold_at_31: got %0d expected 2", oState);
        end
        iBit_counter_key = KW'(KEY_SIZE);
        step();
        checks++;
        if (oState !== 3'd3) begin
            failures++;
            $display("FAIL gap_advance_at_32: got %0d expected 3", oState);
        end
        iAbort = 1; step(); iAbort = 0;
        checks++;
        if ({oState, oDp_rst_n} !== {3'd0, 1'b0}) begin
            failures++;
            $display("FAIL gap_abort: got state=%0d dp=%b expected 0 0", oState, oDp_rst_n);
        end
        step();
        clear_inputs();
    endtask

    task automatic test_abort();
        clear_inputs();
        enter_load_key();
        iBit_counter_key = '1;
        step();
        iBit_counter_msg = '1;
        step();
        checks++;
        if (oState !== 3'd4) begin
            failures++;
            $display("FAIL abort_overrange_counts: got %0d expected 4", oState);
        end
        iEncrypt_done = 1; step(); iEncrypt_done = 0;
        iAbort = 1; step(); iAbort = 0;
        checks++;
        if ({oState, oDp_rst_n, oDone, oBusy} !== {3'd0, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL abort_shift_out: got state=%0d dp=%b done=%b busy=%b expected 0 0 0 0",
                     oState, oDp_rst_n, oDone, oBusy);
        end
        step();
        checks++;
        if ({oState, oDp_rst_n, oDone} !== {3'd0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL abort_recover: got state=%0d dp=%b done=%b expected 0 1 0", oState, oDp_rst_n, oDone);
        end
        iAbort = 1; iStart = 1; step(); iAbort = 0; iStart = 0;
        checks++;
        if ({oState, oDp_rst_n} !== {3'd0, 1'b1}) begin
            failures++;
            $display("FAIL abort_start_idle: got state=%0d dp=%b expected 0 1", oState, oDp_rst_n);
        end
        clear_inputs();
    endtask

    task automatic stall_in_load_msg(output int n);
        clear_inputs();
        enter_load_key();
        iBit_counter_key = KW'(KEY_SIZE);
        step();
        n = 0;
        while (oState !== 3'd7 && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic test_watchdog();
        int n;
        stall_in_load_msg(n);
`ifdef XOR_CTRL_WDT_EN
        checks++;
        if (oState !== 3'd7 || n < TIMEOUT || n > TIMEOUT + 1) begin
            failures++;
            $display("FAIL wdt_timeout: got state=%0d after %0d cycles expected 7 after 16..17", oState, n);
        end
        step();
        checks++;
        if ({oState, oError, oBusy} !== {3'd7, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL wdt_error_held: got state=%0d err=%b busy=%b expected 7 1 0", oState, oError, oBusy);
        end
        iStart = 1; step(); iStart = 0;
        checks++;
        if ({oState, oError} !== {3'd1, 1'b0}) begin
            failures++;
            $display("FAIL wdt_restart: got state=%0d err=%b expected 1 0", oState, oError);
        end
        iAbort = 1; step(); iAbort = 0; step();
        stall_in_load_msg(n);
        iAbort = 1; iStart = 1; step(); iAbort = 0; iStart = 0;
        checks++;
        if ({oState, oError} !== {3'd0, 1'b0}) begin
            failures++;
            $display("FAIL wdt_abort_start_in_error: got state=%0d err=%b expected 0 0", oState, oError);
        end
`else
        checks++;
        if ({oState, oError} !== {3'd3, 1'b0}) begin
            failures++;
            $display("FAIL nowdt_wait: got state=%0d err=%b after %0d cycles expected 3 0", oState, oError, n);
        end
        iAbort = 1; step(); iAbort = 0;
`endif
        step();
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        logic [8:0] got;
        clear_inputs();
        enter_load_key();
        iBit_counter_key = KW'(KEY_SIZE);
        step();
        iSerial_valid = 1; iBit_counter_msg = MW'(100);
        #2 iRst = 0;
        #1;
        got = {oState, oDp_rst_n, oLoad_key, oLoad_msg, oEn, oBusy, oDone, oError};
        checks++;
        if (got !== 10'b000_1_000000) begin
            failures++;
            $display("FAIL reset_mid_msg: got %b expected %b", got, 10'b000_1_000000);
        end
        step();
        iRst = 1;
        step();
        checks++;
        if (oState !== 3'd0) begin
            failures++;
            $display("FAIL reset_mid_release: got %0d expected 0", oState);
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_gapped();
        test_abort();
        test_watchdog();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no completion expected finish before 1ms");
        $fatal(1);
    end

endmodule
